// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: op encodings and sequencer states.
// The iterative multiplier is built only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_SHL      = 3'b001;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;
    localparam logic [2:0] ALU_MUL      = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq single-cycle datapath: next result and flags for the non-MUL ops.
// cntrl=111 falls through to PASS_B here; the sequencer owns the real multiply.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       cntrl_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o,
    output logic             cout_o
);

    localparam int SHW = $clog2(WIDTH);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             c_msb;

    // SUB shares the adder as A + ~B + 1
    assign sub   = (cntrl_i == ALU_SUBTRACT);
    assign b_eff = sub ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign c_msb = a_i[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];

    always_comb begin
        res_o  = b_i;
        ovf_o  = 1'b0;
        cout_o = 1'b0;
        unique case (cntrl_i)
            ALU_SHL: res_o = a_i << b_i[SHW-1:0];
            ALU_ADD, ALU_SUBTRACT: begin
                res_o  = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
                ovf_o  = c_msb ^ sum[WIDTH];
            end
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            default: res_o = b_i;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered-output execute ALU with valid/ready handshake.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle shift-add multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             busy
);

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_cout;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .a_i    (A),
        .b_i    (B),
        .cntrl_i(cntrl),
        .res_o  (alu_res),
        .ovf_o  (alu_ovf),
        .cout_o (alu_cout)
    );

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;
    logic             accept;
    logic             consume;

    assign consume = out_valid_q && out_ready;
    assign accept  = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     part;

    assign in_ready = reset_n && (state_q == IDLE)
                      && (!out_valid_q || out_ready);
    assign busy     = (state_q == MUL);

    // Multiplier sits in the low half of acc and shifts out as product bits fill in
    assign addend = acc_q[0] ? mcand_q : '0;
    assign part   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
`else
    assign in_ready = reset_n && (!out_valid_q || out_ready);
    assign busy     = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        cout_d      = cout_q;
        if (consume) out_valid_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept && cntrl == ALU_MUL) begin
                    state_d = MUL;
                    mcand_d = A;
                    acc_d   = {{WIDTH{1'b0}}, B};
                    cnt_d   = '0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    ovf_d       = alu_ovf;
                    cout_d      = alu_cout;
                end
            end
            MUL: begin
                acc_d = {part, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = acc_d[WIDTH-1:0];
                    ovf_d       = |acc_d[2*WIDTH-1:WIDTH];
                    cout_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            ovf_d       = alu_ovf;
            cout_d      = alu_cout;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            cout_q      <= cout_d;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign negative  = result_q[WIDTH-1];
    assign zero      = ~|result_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: 64-bit single-cycle ops and 8-bit multiply.
// Multiply checks follow ALU_SEQ_MUL_EN; otherwise cntrl=111 is checked as PASS_B.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn64, iv64, ir64, ov64, or64, ng64, z64, o64, c64, bz64;
    logic [63:0] a64, b64, res64;
    logic [2:0]  op64;

    logic        rn8, iv8, ir8, ov8, or8, ng8, z8, o8, c8, bz8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  op8;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(64)) u64 (
        .clk(clk), .reset_n(rn64), .in_valid(iv64), .in_ready(ir64),
        .A(a64), .B(b64), .cntrl(op64), .out_valid(ov64),
        .out_ready(or64), .result(res64), .negative(ng64), .zero(z64),
        .overflow(o64), .carry_out(c64), .busy(bz64)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(rn8), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .cntrl(op8), .out_valid(ov8),
        .out_ready(or8), .result(res8), .negative(ng8), .zero(z8),
        .overflow(o8), .carry_out(c8), .busy(bz8)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        v;
        logic        c;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

`ifdef ALU_SEQ_MUL_EN
    task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic v);
        int lat;
        int bcnt;
        int rdyb;
        bit got;
        @(negedge clk);
        iv8 = 1'b1; op8 = ALU_MUL; a8 = a; b8 = b; or8 = 1'b1;
        @(posedge clk); #1;
        // keep a different op valid the whole time; it must wait
        op8 = ALU_PASS_B; a8 = 8'hAA; b8 = 8'h55;
        lat = 0; bcnt = 0; rdyb = 0; got = 1'b0;
        if (bz8) bcnt++;
        if (ir8) rdyb++;
        for (int j = 1; j <= 40 && !got; j++) begin
            @(posedge clk); #1;
            if (ov8) begin
                got = 1'b1;
                lat = j;
            end else begin
                if (bz8) bcnt++;
                if (ir8) rdyb++;
            end
        end
        chk("mul_latency", lat, 8);
        chk("mul_busy_cycles", bcnt, 8);
        chk("mul_ready_while_busy", rdyb, 0);
        chk("mul_result", res8, r);
        chk("mul_overflow", o8, v);
        chk("mul_carry", c8, 0);
        chk("mul_busy_done", bz8, 0);
        @(posedge clk); #1;
        chk("mul_next_valid", ov8, 1);
        chk("mul_next_result", res8, 8'h55);
        iv8 = 1'b0;
        @(posedge clk); #1;
        chk("mul_drain", ov8, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;

        tbl[0]  = '{ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
                    64'h8000_0000_0000_0000, 1'b1, 1'b0};
        tbl[1]  = '{ALU_SUBTRACT, 64'h2, 64'h4,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[2]  = '{ALU_SHL, 64'h1, 64'h41, 64'h2, 1'b0, 1'b0};
        tbl[3]  = '{ALU_AND, 64'h4, 64'h3, 64'h0, 1'b0, 1'b0};
        tbl[4]  = '{ALU_OR, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0};
        tbl[5]  = '{ALU_XOR, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0};
        tbl[6]  = '{ALU_PASS_B, 64'h5, 64'h7, 64'h7, 1'b0, 1'b0};
        tbl[7]  = '{ALU_SUBTRACT, 64'h5, 64'h3, 64'h2, 1'b0, 1'b1};
        tbl[8]  = '{ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                    64'h0, 1'b0, 1'b1};
        tbl[9]  = '{ALU_SUBTRACT, 64'h8000_0000_0000_0000, 64'h1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[10] = '{ALU_SHL, 64'h8000_0000_0000_0001, 64'd63,
                    64'h8000_0000_0000_0000, 1'b0, 1'b0};

        // reset held two cycles with a valid op offered
        rn64 = 1'b0; iv64 = 1'b1; op64 = ALU_ADD; a64 = 64'd1; b64 = 64'd1;
        or64 = 1'b1;
        rn8 = 1'b0; iv8 = 1'b1; op8 = ALU_MUL; a8 = 8'd3; b8 = 8'd5;
        or8 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", ov64, 0);
        chk("rst_zero", z64, 1);
        chk("rst_in_ready", ir64, 0);
        chk("rst_result", res64, 0);
        chk("rst_flags", {ng64, o64, c64, bz64}, 0);
        chk("rst8_out_valid", ov8, 0);
        chk("rst8_busy", bz8, 0);
        chk("rst8_in_ready", ir8, 0);
        rn64 = 1'b1; iv64 = 1'b0;
        rn8 = 1'b1; iv8 = 1'b0;
        @(negedge clk);
        chk("rst_no_accept", ov64, 0);
        chk("rst8_no_accept", ov8, 0);

        // back-to-back single-cycle vectors
        op64 = tbl[0].op; a64 = tbl[0].a; b64 = tbl[0].b; iv64 = 1'b1;
        #1 chk("tbl_ready", ir64, 1);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), ov64, 1);
            chk($sformatf("tbl%0d_result", i), res64, tbl[i].r);
            chk($sformatf("tbl%0d_overflow", i), o64, tbl[i].v);
            chk($sformatf("tbl%0d_carry", i), c64, tbl[i].c);
            chk($sformatf("tbl%0d_negative", i), ng64, tbl[i].r[63]);
            chk($sformatf("tbl%0d_zero", i), z64, tbl[i].r == 64'd0);
            if (i + 1 < NV) begin
                op64 = tbl[i+1].op; a64 = tbl[i+1].a; b64 = tbl[i+1].b;
            end else begin
                iv64 = 1'b0;
            end
        end

        // back-pressure: ADD 1+1 held, queued XOR 12^12 waits
        @(negedge clk);
        op64 = ALU_ADD; a64 = 64'd1; b64 = 64'd1; iv64 = 1'b1;
        @(negedge clk);
        or64 = 1'b0; op64 = ALU_XOR; a64 = 64'd12; b64 = 64'd12;
        #1;
        chk("bp_valid", ov64, 1);
        chk("bp_result", res64, 2);
        chk("bp_ready_low", ir64, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_result", i), res64, 2);
            chk($sformatf("bp_hold%0d_valid", i), ov64, 1);
            chk($sformatf("bp_hold%0d_ready", i), ir64, 0);
        end
        or64 = 1'b1;
        #1 chk("bp_release_ready", ir64, 1);
        @(negedge clk);
        iv64 = 1'b0;
        chk("bp_xor_valid", ov64, 1);
        chk("bp_xor_result", res64, 0);
        chk("bp_xor_zero", z64, 1);
        @(negedge clk);
        chk("bp_drained", ov64, 0);

`ifdef ALU_SEQ_MUL_EN
        mul8(8'h10, 8'h11, 8'h10, 1'b1);
        mul8(8'd3, 8'd5, 8'd15, 1'b0);
        mul8(8'd0, 8'hFF, 8'd0, 1'b0);

        // reset during the third multiply cycle aborts it
        @(negedge clk);
        iv8 = 1'b1; op8 = ALU_MUL; a8 = 8'h10; b8 = 8'h11;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_before", bz8, 1);
        rn8 = 1'b0;
        @(posedge clk); #1;
        rn8 = 1'b1;
        chk("abort_busy", bz8, 0);
        chk("abort_zero", z8, 1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov8) cnt++;
        end
        chk("abort_no_valid", cnt, 0);
`else
        @(negedge clk);
        iv8 = 1'b1; op8 = ALU_MUL; a8 = 8'd3; b8 = 8'd9;
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("mulpass_valid", ov8, 1);
        chk("mulpass_result", res8, 9);
        chk("mulpass_overflow", o8, 0);
        chk("mulpass_busy", bz8, 0);
`endif

        iv8 = 1'b1; op8 = ALU_PASS_B; a8 = 8'd1; b8 = 8'd7;
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("pass7_valid", ov8, 1);
        chk("pass7_result", res8, 7);
        chk("pass7_flags", {o8, c8, ng8}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered-output ALU for the pipelined CPU execute stage.
- Keeps the existing op encoding (PASS_B/ADD/SUB/AND/OR/XOR) and adds a barrel shift and an iterative multiply.
- Operands move through a valid/ready handshake.
- Single-cycle ops issue back-to-back; multiply occupies the block for WIDTH cycles.

Parameters:
- WIDTH, 64, operand/result width; must be a power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- cntrl  in  3  op select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- result  out  WIDTH  registered result
- negative  out  1  result[WIDTH-1]
- zero  out  1  result == 0
- overflow  out  1  signed overflow (add/sub); product overflow (mul)
- carry_out  out  1  carry out of MSB (add/sub)
- busy  out  1  multiply in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n, sampled on the rising clk edge.
- Reset values: state=IDLE, out_valid=0, busy=0, result=0, negative=0, zero=1, overflow=0, carry_out=0.
- Op map:
  - 000 PASS_B
  - 001 SHL: A << B[SHW-1:0], logical
  - 010 ADD: A+B
  - 011 SUB: A+~B+1
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MUL: low WIDTH bits of unsigned A*B
- Flags:
  - ADD/SUB: carry_out = carry of bit WIDTH-1; overflow = carry into MSB XOR carry out of MSB. SUB carry_out=1 means no borrow (A>=B unsigned).
  - PASS_B/SHL/AND/OR/XOR: overflow=0, carry_out=0.
  - MUL: overflow=1 iff the upper WIDTH product bits are nonzero; carry_out=0.
  - negative/zero are always derived from the registered result.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from state/out_valid/out_ready only, never from in_valid.
- Single-cycle op accepted at edge k: result/flags registered at edge k, out_valid=1 from edge k. Latency 1 cycle; throughput 1/cycle under out_ready=1.
- Output hold: while out_valid && !out_ready, result/flags/out_valid hold stable and in_ready=0.
- States:
  - IDLE: on accept with cntrl=111, go to MUL. Load a WIDTH-bit multiplicand, multiplier, 2*WIDTH accumulator, and count=0. out_valid clears if it was being consumed the same edge. busy=1.
  - MUL: each cycle, if multiplier LSB=1, add the shifted multiplicand into the accumulator; shift; count++. When count==WIDTH-1, the final iteration completes and the result/flags register, out_valid=1, busy=0, and the state returns to IDLE.
  - Result: MUL accepted at edge k yields out_valid at edge k+WIDTH.
- Simultaneous out-handshake and new in-handshake in the same cycle: the new result replaces the old with no bubble.
- A/B/cntrl are ignored while in MUL. in_valid may stay high; no accept occurs until IDLE.
- reset_n low during MUL aborts the operation. Registers reach reset values at that edge; no partial result is ever presented.
- MUL with A=0 or B=0 still takes WIDTH cycles (fixed latency, no early exit).
- SHL amount >= WIDTH cannot occur because the amount is masked to SHW bits.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL state, counter, accumulator and busy logic present, as above.
- Undefined: cntrl=111 executes as PASS_B in a single cycle with overflow=0. busy is tied 0 and the MUL state does not exist.

Decomposition:
- Package alu_seq_pkg:
  - op constants ALU_PASS_B, ALU_SHL, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR, ALU_MUL (3-bit)
  - state enum {IDLE, MUL}
- One sub-module, alu_seq_comb: the combinational datapath computing the next result and flags for the single-cycle ops, parametrised by WIDTH.
- The sequencing, handshake and multiplier live in alu_seq.

Test Plan:
- Reset: hold reset_n=0 two cycles while in_valid=1 -> out_valid=0, zero=1, in_ready=0 during reset, and no accept.
- WIDTH=64, ADD A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> one cycle later result=64'h8000_0000_0000_0000, overflow=1, negative=1, carry_out=0. Then SUB A=2, B=4 back-to-back -> result=64'hFFFF_FFFF_FFFF_FFFE, carry_out=0, negative=1.
- Back-pressure: ADD 1+1 with out_ready=0 for 3 cycles -> result=2 held, in_ready=0. Release -> next queued XOR 12^12 gives result=0, zero=1 the following cycle.
- WIDTH=8 instance, MUL A=8'h10, B=8'h11 -> out_valid exactly 8 cycles after accept, result=8'h10, overflow=1, busy=1 for those 8 cycles. MUL A=3, B=5 -> result=15, overflow=0.
- SHL WIDTH=64, A=1, B=64'h41 -> result=2 (amount masked to 1). AND A=4, B=3 -> result=0, zero=1, overflow=0, carry_out=0.
- reset_n low mid-MUL at cycle 3 of 8 -> no out_valid after reset, and the next op (PASS_B B=7) returns result=7 with 1-cycle latency. With ALU_SEQ_MUL_EN undefined, cntrl=111, B=9 -> result=9 in 1 cycle.
